// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the SRAM bank array and its per-bank macro model.
package sram_bank_pkg;
  typedef enum logic {INIT, READY} state_t;

  // One byte lane of a byte-enabled write: take the new byte only when enabled.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/sram_bank_if.sv
// Registered bank-side bus between the AXI SRAM wrapper (master) and the bank array (slave).
interface sram_bank_if #(
  parameter int ROWS = 1,
  parameter int COLS = 1,
  parameter int AW   = 16,
  parameter int DW   = 32
);
  logic [AW-1:0]                       bank_addr;
  logic [ROWS-1:0][COLS-1:0]           bank_cs;
  logic [ROWS-1:0][COLS-1:0]           bank_we;
  logic [ROWS-1:0][COLS-1:0][DW/8-1:0] bank_be;
  logic [COLS-1:0][DW-1:0]             bank_wdata;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]   bank_rdata;
  logic                                init_done_o;
  logic                                err_o;

  modport master (output bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
                  input  bank_rdata, init_done_o, err_o);
  modport slave  (input  bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
                  output bank_rdata, init_done_o, err_o);
endinterface

// File: rtl/sram_macro_model.sv
// Behavioural stand-in for one SRAM hard macro: storage, byte-merge write,
// fixed-latency read pipeline and an rdata register that holds between reads.
module sram_macro_model import sram_bank_pkg::*; #(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cs_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  localparam int NB = DW/8;

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_word, wr_word, out_dat, rdata_q, rdata_d;
  logic          rd_en, wr_en, out_vld;

  assign rd_en   = cs_i & ~we_i;
  assign wr_en   = cs_i & we_i;
  assign rd_word = mem_q[addr_i];

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < NB; b++)
      wr_word[b*8 +: 8] = be_merge(rd_word[b*8 +: 8], wdata_i[b*8 +: 8], be_i[b]);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[addr_i] <= wr_word;
  end

  // The rdata register is the last stage, so only LAT-1 stages sit in front of it.
  if (LAT == 1) begin : g_lat1
    assign out_vld = rd_en;
    assign out_dat = rd_word;
  end else begin : g_pipe
    logic [LAT-2:0]         vld_pipe_q, vld_pipe_d;
    logic [LAT-2:0][DW-1:0] dat_pipe_q, dat_pipe_d;

    always_comb begin
      vld_pipe_d    = vld_pipe_q;
      dat_pipe_d    = dat_pipe_q;
      vld_pipe_d[0] = rd_en;
      dat_pipe_d[0] = rd_word;
      for (int k = 1; k < LAT-1; k++) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        dat_pipe_d[k] = dat_pipe_q[k-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_pipe_q <= '0;
        dat_pipe_q <= '0;
      end else begin
        vld_pipe_q <= vld_pipe_d;
        dat_pipe_q <= dat_pipe_d;
      end
    end

    assign out_vld = vld_pipe_q[LAT-2];
    assign out_dat = dat_pipe_q[LAT-2];
  end

  assign rdata_d = out_vld ? out_dat : rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_bank_array.sv
// ROWS x COLS SRAM bank array: post-reset zero sweep, request muxing and a
// sticky protocol-error flag around an array of per-bank macro models.
module sram_bank_array import sram_bank_pkg::*; #(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 16,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_READ_LATENCY    = 2,
  parameter int INIT_ZERO            = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  sram_bank_if.slave bus
);
  localparam int R  = SRAM_BANKS_ROWS;
  localparam int C  = SRAM_BANKS_COLS;
  localparam int AW = SRAM_BANK_ADDR_WIDTH;
  localparam int DW = SRAM_BANK_DATA_WIDTH;
  localparam int NB = DW/8;

  state_t                     state_q, state_d;
  logic [AW-1:0]              init_cnt_q, init_cnt_d;
  logic                       init_done_q, init_done_d;
  logic                       err_q, err_d;
  logic [R-1:0][C-1:0]        mac_cs, mac_we;
  logic [R-1:0][C-1:0][NB-1:0] mac_be;
  logic [AW-1:0]              mac_addr;
  logic [C-1:0][DW-1:0]       mac_wdata;
  logic [R-1:0][C-1:0][DW-1:0] rdata;
  logic                       partial_row;
  int unsigned                rows_hit;

  always_comb begin
    rows_hit    = 0;
    partial_row = 1'b0;
    for (int r = 0; r < R; r++) begin
      if (|bus.bank_cs[r]) rows_hit++;
      if (|bus.bank_cs[r] && !(&bus.bank_cs[r])) partial_row = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    mac_cs      = bus.bank_cs;
    mac_we      = bus.bank_we;
    mac_be      = bus.bank_be;
    mac_addr    = bus.bank_addr;
    mac_wdata   = bus.bank_wdata;
    if (rows_hit > 1 || partial_row) err_d = 1'b1;
    case (state_q)
      INIT: begin
        if (|bus.bank_cs) err_d = 1'b1;
        mac_cs = '0;
        if (INIT_ZERO != 0) begin
          // Sweep owns every bank: full-width zero write at init_cnt.
          mac_cs     = '1;
          mac_we     = '1;
          mac_be     = '1;
          mac_addr   = init_cnt_q;
          mac_wdata  = '0;
          init_cnt_d = init_cnt_q + 1'b1;
          if (&init_cnt_q) begin
            state_d     = READY;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst_i) mac_cs = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    for (genvar c = 0; c < C; c++) begin : g_col
      sram_macro_model #(
        .AW (AW),
        .DW (DW),
        .LAT(SRAM_READ_LATENCY)
      ) u_mac (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cs_i   (mac_cs[r][c]),
        .we_i   (mac_we[r][c]),
        .addr_i (mac_addr),
        .be_i   (mac_be[r][c]),
        .wdata_i(mac_wdata[c]),
        .rdata_o(rdata[r][c])
      );
    end
  end

  assign bus.bank_rdata  = rdata;
  assign bus.init_done_o = init_done_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_sram_bank_array.sv
// Randomized scoreboard bench for sram_bank_array (2x2 banks, AW=4, DW=32, LAT=2).
module tb_sram_bank_array;
  localparam int ROWS = 2, COLS = 2, AW = 4, DW = 32, LAT = 2;
  localparam int DEPTH = 1 << AW;
  localparam int BIG = 32'h7fff_ffff;
  localparam int EV_RD = 0, EV_ERR = 1, EV_RST = 2, EV_DONE = 3;

  typedef struct {
    int          edge_n;
    int          kind;
    int          r;
    int          c;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_edge;
  ev_t  evq[$];
  logic [31:0] mem_m [ROWS][COLS][DEPTH];
  logic [31:0] exp_rd [ROWS][COLS];
  logic        exp_err, exp_done;

  sram_bank_if #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .DW(DW)) bus ();

  sram_bank_array #(
    .SRAM_BANKS_ROWS     (ROWS),
    .SRAM_BANKS_COLS     (COLS),
    .SRAM_BANK_ADDR_WIDTH(AW),
    .SRAM_BANK_DATA_WIDTH(DW),
    .SRAM_READ_LATENCY   (LAT),
    .INIT_ZERO           (1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: retire scoreboard events whose edge has passed, then compare every output.
  always @(negedge clk) begin
    bit hit;
    hit = 0;
    foreach (evq[i]) if (evq[i].kind == EV_RST && evq[i].edge_n <= cyc) hit = 1;
    if (hit) begin
      evq.delete();
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_rd[r][c] = '0;
      exp_err  = 1'b0;
      exp_done = 1'b0;
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].edge_n <= cyc) begin
        case (evq[i].kind)
          EV_RD:   exp_rd[evq[i].r][evq[i].c] = evq[i].data;
          EV_ERR:  exp_err = 1'b1;
          EV_DONE: exp_done = 1'b1;
          default: ;
        endcase
        evq.delete(i);
      end
    end
    if (cyc > 0) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          chk($sformatf("rdata[%0d][%0d]", r, c), bus.bank_rdata[r][c], exp_rd[r][c]);
      chk("err_o", {31'b0, bus.err_o}, {31'b0, exp_err});
      chk("init_done_o", {31'b0, bus.init_done_o}, {31'b0, exp_done});
    end
  end

  // Driver + reference model: one call drives one request cycle.
  task automatic access(input logic [1:0][1:0] cs, input logic we, input logic [3:0] addr,
                        input logic [1:0][1:0][3:0] be, input logic [1:0][31:0] wd);
    int e, rows;
    bit bad;
    @(posedge clk); #1;
    bus.bank_cs = cs; bus.bank_we = {we, we, we, we}; bus.bank_addr = addr;
    bus.bank_be = be; bus.bank_wdata = wd;
    if (rst) return;
    e = cyc + 1;
    rows = 0; bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (cs[r] != 2'b00) rows++;
      if (cs[r] == 2'b01 || cs[r] == 2'b10) bad = 1;
    end
    if (rows > 1) bad = 1;
    if (e <= ready_edge && cs != '0) bad = 1;
    if (bad) evq.push_back('{e, EV_ERR, 0, 0, 32'h0});
    if (e > ready_edge)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (cs[r][c]) begin
            if (we) begin
              for (int b = 0; b < 4; b++)
                if (be[r][c][b]) mem_m[r][c][addr][b*8 +: 8] = wd[c][b*8 +: 8];
            end else begin
              evq.push_back('{e + LAT - 1, EV_RD, r, c, mem_m[r][c][addr]});
            end
          end
  endtask

  task automatic idle(input int n);
    repeat (n) access('0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic wr_row(input int row, input logic [3:0] addr, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [3:0] b);
    logic [1:0][1:0] cs;
    logic [1:0][1:0][3:0] be;
    cs = '0; be = '0;
    cs[row] = 2'b11; be[row][0] = b; be[row][1] = b;
    access(cs, 1'b1, addr, be, {d1, d0});
  endtask

  task automatic rd_row(input int row, input logic [3:0] addr);
    logic [1:0][1:0] cs;
    cs = '0; cs[row] = 2'b11;
    access(cs, 1'b0, addr, '0, '0);
  endtask

  task automatic assert_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.bank_cs = '0;
    evq.push_back('{cyc + 1, EV_RST, 0, 0, 32'h0});
    ready_edge = BIG;
  endtask

  task automatic release_rst();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int a = 0; a < DEPTH; a++) mem_m[r][c][a] = '0;
    ready_edge = cyc + DEPTH;
    evq.push_back('{cyc + DEPTH, EV_DONE, 0, 0, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0][1:0] cs;
    logic [1:0][1:0][3:0] be;
    rst = 1'b1;
    bus.bank_cs = '0; bus.bank_we = '0; bus.bank_addr = '0; bus.bank_be = '0; bus.bank_wdata = '0;
    ready_edge = BIG;
    exp_err = 1'b0; exp_done = 1'b0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) exp_rd[r][c] = '0;
    evq.push_back('{1, EV_RST, 0, 0, 32'h0});
    release_rst();

    // Zero sweep, then read back a swept word.
    idle(DEPTH + 1);
    rd_row(1, 4'd5);
    idle(2);

    // Byte-enable merge.
    wr_row(0, 4'd3, 32'hDEADBEEF, 32'h01234567, 4'hF);
    wr_row(0, 4'd3, 32'h00005500, 32'hAA00_0000, 4'h2);
    rd_row(0, 4'd3);
    idle(3);

    // Back-to-back pipelined reads, then hold.
    wr_row(1, 4'd1, 32'h11, 32'h111, 4'hF);
    wr_row(1, 4'd2, 32'h22, 32'h222, 4'hF);
    wr_row(1, 4'd3, 32'h33, 32'h333, 4'hF);
    rd_row(1, 4'd1);
    rd_row(1, 4'd2);
    rd_row(1, 4'd3);
    idle(4);

    // Write immediately followed by read of the same word.
    wr_row(0, 4'd7, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'hF);
    rd_row(0, 4'd7);
    idle(3);

    // Random legal traffic (one full row or idle per cycle).
    for (int i = 0; i < 200; i++) begin
      cs = '0; be = '0;
      if ($urandom_range(0, 3) != 0) cs[$urandom_range(0, 1)] = 2'b11;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) be[r][c] = 4'($urandom_range(0, 15));
      access(cs, 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), be,
             {32'($urandom()), 32'($urandom())});
    end
    idle(3);

    // Reset one cycle after a read: the read must never land.
    wr_row(0, 4'd9, 32'hC0FFEE00, 32'hBADC0DE0, 4'hF);
    rd_row(0, 4'd9);
    assert_rst();
    release_rst();

    // Accesses during INIT are ignored and flag an error.
    idle(8);
    wr_row(0, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF);
    rd_row(1, 4'd2);
    idle(DEPTH);
    rd_row(0, 4'd3);
    rd_row(0, 4'd7);
    idle(4);

    // Both rows selected in one cycle.
    assert_rst();
    release_rst();
    idle(DEPTH + 1);
    wr_row(1, 4'd4, 32'h12345678, 32'h9ABCDEF0, 4'hF);
    access(4'b1111, 1'b0, 4'd4, '0, '0);
    idle(5);

    // Partial row select.
    assert_rst();
    release_rst();
    idle(DEPTH + 1);
    access(4'b0001, 1'b1, 4'd2, '1, {32'h0, 32'h77777777});
    rd_row(0, 4'd2);
    idle(LAT + 3);

    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0 pending events", evq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
